echo_repeat_fifo: RTL

Parametrised successor to the single-entry echo block. Buffers up to DEPTH request words in an internal FIFO. Replays each word to the indication interface a per-word programmable number of times, tagging each replay with its index. Sits between a request proxy (say method) and an indication proxy (heard method). Uses the method-style __ENA/__RDY handshake used throughout the generated design.

---
 rtl/echo_repeat_fifo_pkg.sv | 19 +
 rtl/echo_repeat_fifo_if.sv | 39 +++
 rtl/echo_repeat_fifo_fifo_n.sv | 68 ++++++
 rtl/echo_repeat_fifo.sv | 73 +++++++
 4 files changed

// File: rtl/echo_repeat_fifo_pkg.sv
// Shared constants and types for the echo repeat FIFO.
package echo_pkg;

    localparam int ECHO_WIDTH = 32;
    localparam int ECHO_DEPTH = 4;
    localparam int ECHO_REPW  = 4;

    // Stored entry at the default widths: replay count above payload.
    typedef struct packed {
        logic [ECHO_REPW-1:0]  rep;
        logic [ECHO_WIDTH-1:0] v;
    } echo_entry_t;

    // Occupancy counter width able to hold the value DEPTH itself.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/echo_repeat_fifo_if.sv
// Method-style say / respond_rule / heard handshake bundle.
interface echo_repeat_fifo_if
    import echo_pkg::*;
#(
    parameter int WIDTH = ECHO_WIDTH,
    parameter int DEPTH = ECHO_DEPTH,
    parameter int REPW  = ECHO_REPW
);

    localparam int CW = cnt_width(DEPTH);

    logic             say__ENA;
    logic [WIDTH-1:0] say_v;
    logic [REPW-1:0]  say_rep;
    logic             say__RDY;
    logic             respond_rule__ENA;
    logic             respond_rule__RDY;
    logic             ind_heard__ENA;
    logic [WIDTH-1:0] ind_heard_v;
    logic [REPW-1:0]  ind_heard_idx;
    logic             ind_heard_last;
    logic             ind_heard__RDY;
    logic [CW-1:0]    count;

    // Echo block side.
    modport slave (
        input  say__ENA, say_v, say_rep, respond_rule__ENA, ind_heard__RDY,
        output say__RDY, respond_rule__RDY, ind_heard__ENA, ind_heard_v,
               ind_heard_idx, ind_heard_last, count
    );

    // Request proxy / scheduler / indication proxy side.
    modport master (
        output say__ENA, say_v, say_rep, respond_rule__ENA, ind_heard__RDY,
        input  say__RDY, respond_rule__RDY, ind_heard__ENA, ind_heard_v,
               ind_heard_idx, ind_heard_last, count
    );

endinterface

// File: rtl/echo_repeat_fifo_fifo_n.sv
// DEPTH-entry circular FIFO; full/empty tracked by an occupancy counter.
module fifo_n
    import echo_pkg::*;
#(
    parameter int DEPTH = ECHO_DEPTH,
    parameter int DW    = ECHO_WIDTH + ECHO_REPW
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enq_en,
    input  logic [DW-1:0]               enq_data,
    output logic                        enq_rdy,
    input  logic                        deq_en,
    output logic                        deq_rdy,
    output logic [DW-1:0]               first,
    output logic [cnt_width(DEPTH)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_width(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          enq_fire, deq_fire;

    // Ready flags come from registered occupancy only.
    assign enq_rdy  = (count_q != CW'(DEPTH));
    assign deq_rdy  = (count_q != '0);
    assign enq_fire = enq_en & enq_rdy;
    assign deq_fire = deq_en & deq_rdy;
    assign first    = mem_q[rd_ptr_q];
    assign count    = count_q;

    // Next-state pointers and occupancy; pointers wrap at DEPTH (power of two).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (enq_fire) wr_ptr_d = wr_ptr_q + AW'(1);
        if (deq_fire) rd_ptr_d = rd_ptr_q + AW'(1);
        case ({enq_fire, deq_fire})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are not reset.
    always_ff @(posedge clk) begin
        if (enq_fire && !rst) mem_q[wr_ptr_q] <= enq_data;
    end

endmodule

// File: rtl/echo_repeat_fifo.sv
// Buffers say requests and replays each head word rep+1 times on heard.
module echo_repeat_fifo
    import echo_pkg::*;
#(
    parameter int WIDTH = ECHO_WIDTH,
    parameter int DEPTH = ECHO_DEPTH,
    parameter int REPW  = ECHO_REPW
) (
    input  logic               CLK,
    input  logic               RST,
    echo_repeat_fifo_if.slave  io
);

    typedef struct packed {
        logic [REPW-1:0]  rep;
        logic [WIDTH-1:0] v;
    } entry_t;

    localparam int DW = $bits(entry_t);

    entry_t          head;
    entry_t          enq_entry;
    logic [DW-1:0]   fifo_first;
    logic            fifo_enq_rdy;
    logic            fifo_deq_rdy;
    logic            fifo_deq_en;
    logic            fire;
    logic            is_last;
    logic [REPW-1:0] rep_cnt_q, rep_cnt_d;

    assign enq_entry = '{rep: io.say_rep, v: io.say_v};

    fifo_n #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_fifo (
        .clk      (CLK),
        .rst      (RST),
        .enq_en   (io.say__ENA),
        .enq_data (enq_entry),
        .enq_rdy  (fifo_enq_rdy),
        .deq_en   (fifo_deq_en),
        .deq_rdy  (fifo_deq_rdy),
        .first    (fifo_first),
        .count    (io.count)
    );

    assign head    = entry_t'(fifo_first);
    // Compare before increment so rep = all-ones never wraps rep_cnt.
    assign is_last = (rep_cnt_q == head.rep);
    assign fire    = io.respond_rule__ENA & io.respond_rule__RDY;
    assign fifo_deq_en = fire & is_last;

    assign io.say__RDY          = fifo_enq_rdy;
    assign io.respond_rule__RDY = fifo_deq_rdy & io.ind_heard__RDY;
    assign io.ind_heard__ENA    = io.respond_rule__ENA;
    assign io.ind_heard_v       = head.v;
    assign io.ind_heard_idx     = rep_cnt_q;
    assign io.ind_heard_last    = is_last;

    // Replay index: advance per emission, clear when the head is retired.
    always_comb begin
        rep_cnt_d = rep_cnt_q;
        if (fire) rep_cnt_d = is_last ? '0 : rep_cnt_q + REPW'(1);
    end

    // Replay index register with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) rep_cnt_q <= '0;
        else     rep_cnt_q <= rep_cnt_d;
    end

endmodule
